// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC accumulator front end.
package mac_pkg;
  localparam int PSUM_WIDTH  = 25;
  localparam int PSUM_LANES  = 4;
  localparam int SEL_WIDTH   = 3;
  localparam int ACC_LATENCY = 2;

  typedef logic signed [PSUM_WIDTH-1:0] psum_vec_t [PSUM_LANES];
  typedef logic [SEL_WIDTH-1:0]         sel_t;
endpackage

// File: rtl/mac_sync_fifo.sv
// Synchronous FIFO with a combinational head read, used as input queue and result skid.
module mac_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_push = push_i && !full;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Callers gate pushes with their own credit/ready logic; a push into a full FIFO is a bug.
  no_overflow_a: assert property (@(posedge clk) disable iff (reset) !(push_i && full));
endmodule

// File: rtl/mac_psum_issuer.sv
// Issues buffered psum vectors to the MAC accumulator and collects its results in a skid FIFO.
// Optional: define MAC_PSUM_ISSUER_STATS_EN to build the issue_count counter.
module mac_psum_issuer
  import mac_pkg::*;
#(
  parameter int DATA_WIDTH = PSUM_WIDTH,
  parameter int VEC_LENGTH = PSUM_LANES,
  parameter int DEPTH      = 4,
  parameter int RES_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_psum [VEC_LENGTH],
  input  sel_t                         in_sel,
  input  logic                         in_last,
  output logic                         acc_en,
  output logic signed [DATA_WIDTH-1:0] acc_accu [VEC_LENGTH],
  output sel_t                         acc_se,
  input  logic signed [DATA_WIDTH+1:0] acc_result,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [DATA_WIDTH+1:0] res_data,
  output logic                         res_last,
  output logic                         busy,
  output logic [15:0]                  issue_count
);
  localparam int PSUM_BITS = DATA_WIDTH * VEC_LENGTH;
  localparam int IN_W      = PSUM_BITS + SEL_WIDTH + 1;
  localparam int RES_W     = DATA_WIDTH + 3;
  localparam int IN_CNT_W  = $clog2(DEPTH) + 1;
  localparam int RES_CNT_W = $clog2(RES_DEPTH) + 1;

  logic [IN_W-1:0]      in_wdata, in_rdata;
  logic [IN_CNT_W-1:0]  in_count;
  logic                 in_empty, in_push, issue;
  logic [RES_W-1:0]     res_wdata, res_rdata;
  logic [RES_CNT_W-1:0] res_count;
  logic                 res_empty, res_pop;
  logic [ACC_LATENCY-1:0] tag_v_q, tag_v_d, tag_last_q, tag_last_d;

  for (genvar gi = 0; gi < VEC_LENGTH; gi++) begin : g_lane
    assign in_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = in_psum[gi];
    assign acc_accu[gi] = issue ? $signed(in_rdata[gi*DATA_WIDTH +: DATA_WIDTH]) : '0;
  end
  assign in_wdata[IN_W-1 -: SEL_WIDTH+1] = {in_last, in_sel};

  assign in_ready = (in_count != IN_CNT_W'(DEPTH));
  assign in_push  = in_valid && in_ready;

  mac_sync_fifo #(.WIDTH(IN_W), .DEPTH(DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset),
    .push_i(in_push), .wdata_i(in_wdata), .pop_i(issue),
    .rdata_o(in_rdata), .count_o(in_count), .empty_o(in_empty)
  );

  // Every in-flight vector holds a reserved skid slot, so captures can never overflow the skid.
  assign issue  = !in_empty && (($countones(tag_v_q) + int'(res_count)) < RES_DEPTH);
  assign acc_en = issue;
  assign acc_se = issue ? in_rdata[PSUM_BITS +: SEL_WIDTH] : '0;

  always_comb begin
    tag_v_d    = {tag_v_q[ACC_LATENCY-2:0], issue};
    tag_last_d = {tag_last_q[ACC_LATENCY-2:0], issue & in_rdata[IN_W-1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v_q    <= '0;
      tag_last_q <= '0;
    end else begin
      tag_v_q    <= tag_v_d;
      tag_last_q <= tag_last_d;
    end
  end

  assign res_wdata = {tag_last_q[ACC_LATENCY-1], acc_result};
  assign res_pop   = res_valid && res_ready;

  mac_sync_fifo #(.WIDTH(RES_W), .DEPTH(RES_DEPTH)) u_res_skid (
    .clk(clk), .reset(reset),
    .push_i(tag_v_q[ACC_LATENCY-1]), .wdata_i(res_wdata), .pop_i(res_pop),
    .rdata_o(res_rdata), .count_o(res_count), .empty_o(res_empty)
  );

  assign res_valid = !res_empty;
  assign res_data  = res_valid ? $signed(res_rdata[DATA_WIDTH+1:0]) : '0;
  assign res_last  = res_valid & res_rdata[RES_W-1];
  assign busy      = !in_empty || (|tag_v_q) || !res_empty;

`ifdef MAC_PSUM_ISSUER_STATS_EN
  logic [15:0] issue_count_q, issue_count_d;

  assign issue_count_d = issue ? issue_count_q + 16'd1 : issue_count_q;

  always_ff @(posedge clk) begin
    if (reset) issue_count_q <= '0;
    else       issue_count_q <= issue_count_d;
  end

  assign issue_count = issue_count_q;
`else
  assign issue_count = '0;
`endif
endmodule
